// File: rtl/tamagotchi_tx_scheduler.sv
// Arbitrates the UART TX byte stream between periodic stat reports and command acks.
// Whole frames are latched at frame start and streamed over a valid/ready handshake.
module tamagotchi_tx_scheduler #(
    parameter logic [7:0] REPORT_PERIOD = 8'd5,
    parameter logic [7:0] REPORT_HDR    = 8'hA5,
    parameter logic [7:0] ACK_HDR       = 8'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       second,
    input  logic [4:0] hunger,
    input  logic [4:0] happiness,
    input  logic [4:0] hygiene,
    input  logic [4:0] energy,
    input  logic [4:0] social,
    input  logic       is_sleeping,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [3:0] dropped
);

    typedef enum logic [1:0] {IDLE, REPORT, ACK} state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            last_ack_q, last_ack_d;
    logic [3:0]      drop_q, drop_d;
    logic [7:0][7:0] frame_q, frame_d;

    logic       trig, take_ack, take_rep, xfer;
    logic [2:0] last_idx;
    logic [7:0] rep_cs;

    assign trig     = second && (cnt_q == REPORT_PERIOD - 8'd1);
    assign take_ack = (state_q == IDLE) && cmd_valid && (!pend_q || !last_ack_q);
    assign take_rep = (state_q == IDLE) && !take_ack && pend_q;
    assign xfer     = tx_valid && tx_ready;
    assign last_idx = (state_q == REPORT) ? 3'd7 : 3'd2;
    assign rep_cs   = REPORT_HDR ^ {3'b0, hunger} ^ {3'b0, happiness} ^ {3'b0, hygiene}
                    ^ {3'b0, energy} ^ {3'b0, social} ^ {7'b0, is_sleeping};

    assign tx_valid  = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign cmd_ready = rst_n && (state_q == IDLE);
    assign tx_data   = tx_valid ? frame_q[idx_q] : 8'h00;
    assign dropped   = drop_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        last_ack_d = last_ack_q;
        drop_d     = drop_q;
        frame_d    = frame_q;

        if (second) cnt_d = trig ? 8'd0 : cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (take_ack) begin
                    state_d    = ACK;
                    idx_d      = 3'd0;
                    last_ack_d = 1'b1;
                    frame_d[0] = ACK_HDR;
                    frame_d[1] = cmd_byte;
                    frame_d[2] = ACK_HDR ^ cmd_byte;
                end else if (take_rep) begin
                    state_d    = REPORT;
                    idx_d      = 3'd0;
                    last_ack_d = 1'b0;
                    frame_d[0] = REPORT_HDR;
                    frame_d[1] = {3'b0, hunger};
                    frame_d[2] = {3'b0, happiness};
                    frame_d[3] = {3'b0, hygiene};
                    frame_d[4] = {3'b0, energy};
                    frame_d[5] = {3'b0, social};
                    frame_d[6] = {7'b0, is_sleeping};
                    frame_d[7] = rep_cs;
                end
            end
            default: begin
                if (xfer) begin
                    if (idx_q == last_idx) state_d = IDLE;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
        endcase

        // A trigger coinciding with report entry re-arms pending without counting a drop.
        if (take_rep) begin
            pend_d = trig;
        end else if (trig) begin
            pend_d = 1'b1;
            if (pend_q && drop_q != 4'hF) drop_d = drop_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= 8'd0;
            pend_q     <= 1'b0;
            last_ack_q <= 1'b0;
            drop_q     <= 4'd0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            last_ack_q <= last_ack_d;
            drop_q     <= drop_d;
            frame_q    <= frame_d;
        end
    end

endmodule

// File: tb/tb_tamagotchi_tx_scheduler.sv
// Bench for tamagotchi_tx_scheduler: directed vector table, corner-case sequences,
// and random traffic checked every cycle against a frame-queue reference model.
module tb_tamagotchi_tx_scheduler;

    localparam int P = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       second = 1'b0, second1 = 1'b0;
    logic [4:0] hunger = 5'd0, happiness = 5'd0, hygiene = 5'd0, energy = 5'd0, social = 5'd0;
    logic       is_sleeping = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       tx_ready = 1'b0, tx_ready1 = 1'b0;
    logic       cmd_ready, tx_valid, busy, cmd_ready1, tx_valid1, busy1;
    logic [7:0] tx_data, tx_data1;
    logic [3:0] dropped, dropped1;

    tamagotchi_tx_scheduler #(.REPORT_PERIOD(8'd2)) dut (
        .clk(clk), .rst_n(rst_n), .second(second),
        .hunger(hunger), .happiness(happiness), .hygiene(hygiene), .energy(energy),
        .social(social), .is_sleeping(is_sleeping),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .dropped(dropped)
    );

    tamagotchi_tx_scheduler #(.REPORT_PERIOD(8'd1)) dut1 (
        .clk(clk), .rst_n(rst_n), .second(second1),
        .hunger(hunger), .happiness(happiness), .hygiene(hygiene), .energy(energy),
        .social(social), .is_sleeping(is_sleeping),
        .cmd_valid(1'b0), .cmd_byte(8'h00), .cmd_ready(cmd_ready1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .busy(busy1), .dropped(dropped1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: a pending flag, a period counter and the queue of bytes
    // still owed for the frame in flight.
    logic [7:0] m_q[$];
    bit         m_busy = 0, m_pend = 0, m_last_ack = 0;
    int         m_cnt = 0;
    logic [3:0] m_drop = 4'd0;

    initial forever begin
        bit trig, take_ack, take_rep;
        logic [7:0] cs;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete(); m_busy = 0; m_pend = 0; m_last_ack = 0; m_cnt = 0; m_drop = 4'd0;
        end else begin
            trig     = second && (m_cnt == P - 1);
            if (second) m_cnt = trig ? 0 : m_cnt + 1;
            take_ack = !m_busy && cmd_valid && (!m_pend || !m_last_ack);
            take_rep = !m_busy && !take_ack && m_pend;
            if (m_busy && tx_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 0;
            end else if (take_ack) begin
                m_q.delete();
                m_q.push_back(8'h5A); m_q.push_back(cmd_byte); m_q.push_back(8'h5A ^ cmd_byte);
                m_busy = 1; m_last_ack = 1;
            end else if (take_rep) begin
                m_q.delete();
                m_q.push_back(8'hA5);
                m_q.push_back({3'b0, hunger});  m_q.push_back({3'b0, happiness});
                m_q.push_back({3'b0, hygiene}); m_q.push_back({3'b0, energy});
                m_q.push_back({3'b0, social});  m_q.push_back({7'b0, is_sleeping});
                cs = 8'h00;
                foreach (m_q[i]) cs ^= m_q[i];
                m_q.push_back(cs);
                m_busy = 1; m_last_ack = 0;
            end
            if (take_rep) m_pend = trig;
            else if (trig) begin
                if (m_pend && m_drop != 4'hF) m_drop = m_drop + 4'd1;
                m_pend = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n)
            chk("model {valid,busy,ready,dropped,data}",
                {tx_valid, busy, cmd_ready, dropped, tx_data},
                {m_busy, m_busy, !m_busy, m_drop, (m_busy ? m_q[0] : 8'h00)});
    end

    typedef struct {
        logic       sec;
        logic       cv;
        logic [7:0] cb;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_ready;
    } vec_t;

    function automatic vec_t mk(logic s, logic v, logic [7:0] b, logic ev, logic [7:0] ed, logic er);
        vec_t r;
        r.sec = s; r.cv = v; r.cb = b; r.e_valid = ev; r.e_data = ed; r.e_ready = er;
        return r;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t       vecs[17];
        logic [7:0] rep_exp[8];
        logic [7:0] got[$];
        logic [7:0] hdrs[$];
        logic [7:0] prev_data;
        bit         prev_stall, prev_v;
        int         n;

        rep_exp = '{8'hA5, 8'h0A, 8'h14, 8'h05, 8'h1F, 8'h00, 8'h01, 8'hA0};
        vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 1);
        vecs[1]  = mk(1, 0, 8'h00, 0, 8'h00, 1);
        vecs[2]  = mk(0, 0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) vecs[3 + i] = mk(0, 0, 8'h00, 1, rep_exp[i], 0);
        vecs[11] = mk(0, 0, 8'h00, 0, 8'h00, 1);
        vecs[12] = mk(0, 1, 8'h31, 0, 8'h00, 1);
        vecs[13] = mk(0, 0, 8'h00, 1, 8'h5A, 0);
        vecs[14] = mk(0, 0, 8'h00, 1, 8'h31, 0);
        vecs[15] = mk(0, 0, 8'h00, 1, 8'h6B, 0);
        vecs[16] = mk(0, 0, 8'h00, 0, 8'h00, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {tx_valid, busy, cmd_ready, dropped, tx_data}, 32'h0);
        chk("reset outputs dut1", {tx_valid1, busy1, cmd_ready1, dropped1, tx_data1}, 32'h0);
        hunger = 5'd10; happiness = 5'd20; hygiene = 5'd5; energy = 5'd31; social = 5'd0;
        is_sleeping = 1'b1; tx_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        step();

        // Directed report then ack, one row per cycle.
        for (int i = 0; i < 17; i++) begin
            second = vecs[i].sec; cmd_valid = vecs[i].cv; cmd_byte = vecs[i].cb;
            @(negedge clk);
            chk($sformatf("vec%0d {valid,busy,ready,data}", i),
                {tx_valid, busy, cmd_ready, tx_data},
                {vecs[i].e_valid, vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_data});
            step();
        end
        cmd_valid = 1'b0;

        // Backpressure: tx_ready toggles; stats change mid-frame.
        tx_ready = 1'b0; second = 1'b1; step(); step(); second = 1'b0;
        prev_stall = 0; prev_data = 8'h00;
        for (int c = 0; c < 80 && got.size() < 8; c++) begin
            tx_ready = ~tx_ready;
            @(negedge clk);
            if (prev_stall) chk("stall hold", tx_data, prev_data);
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (got.size() == 1) hunger = 5'd3;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            step();
        end
        chk("backpressure byte count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk($sformatf("backpressure byte%0d", i), got[i], rep_exp[i]);
        hunger = 5'd10; tx_ready = 1'b1; step(); step();

        // Contention: report pending while cmd_valid held high.
        second = 1'b1; step(); step(); second = 1'b0;
        cmd_valid = 1'b1; cmd_byte = 8'h44; prev_v = 0;
        for (int c = 0; c < 60 && hdrs.size() < 3; c++) begin
            @(negedge clk);
            if (tx_valid && !prev_v) hdrs.push_back(tx_data);
            prev_v = tx_valid;
            step();
        end
        chk("contention frame count", hdrs.size(), 3);
        if (hdrs.size() == 3) begin
            chk("contention first", hdrs[0], 8'h5A);
            chk("contention second", hdrs[1], 8'hA5);
            chk("contention third", hdrs[2], 8'h5A);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        chk("drain after contention", busy, 1'b0);

        // Overrun on the period-1 instance with the UART stalled.
        tx_ready1 = 1'b0; second1 = 1'b1;
        repeat (20) step();
        second1 = 1'b0;
        @(negedge clk);
        chk("overrun {valid,busy,ready,data}", {tx_valid1, busy1, cmd_ready1, tx_data1}, {3'b110, 8'hA5});
        chk("overrun dropped", dropped1, 4'hF);
        step();

        // Reset while byte 4 of a report is presented.
        second = 1'b1; step(); step(); second = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (n == 4 && tx_valid) break;
            if (tx_valid && tx_ready) n++;
            step();
        end
        chk("mid-frame byte4", {tx_valid, tx_data}, {1'b1, 8'h1F});
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", {tx_valid, busy, cmd_ready, dropped, tx_data}, 32'h0);
        chk("async reset dut1", {tx_valid1, busy1, dropped1, tx_data1}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        step();
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_valid) n++;
            step();
        end
        chk("no frame after reset", n, 0);
        second = 1'b1; step(); step(); second = 1'b0;
        n = 0;
        while (!tx_valid && n < 10) begin step(); n++; end
        chk("frame after new trigger", {tx_valid, tx_data}, {1'b1, 8'hA5});

        // Random traffic; the model checks every cycle.
        for (int c = 0; c < 1500; c++) begin
            second    = ($urandom_range(0, 3) == 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_byte  = 8'($urandom);
            tx_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                hunger = 5'($urandom); happiness = 5'($urandom); hygiene = 5'($urandom);
                energy = 5'($urandom); social = 5'($urandom); is_sleeping = 1'($urandom);
            end
            step();
        end
        second = 1'b0; cmd_valid = 1'b0; tx_ready = 1'b1;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
